// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-side front end.
//   state_t          : boot loader FSM states
//   NOP_WORD         : value of any unloaded/out-of-range instruction (sll $0,$0,0)
//   IMEM_DEPTH_LOG2  : default log2 word count of the instruction memory
package mips_pkg;
  typedef enum logic [2:0] {CLEAR, HDR_HI, HDR_LO, DATA, RUN} state_t;
  localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
  localparam int          IMEM_DEPTH_LOG2 = 7;
endpackage

// File: rtl/imem_ram.sv
// Generic 2**DEPTH_LOG2 x WIDTH memory: one synchronous write port, one
// asynchronous read port. Intended for reuse on the data-memory side.
//   clk         : write clock
//   we/waddr/wdata : write port, committed at posedge clk
//   raddr/rdata : combinational read port
module imem_ram #(
  parameter int DEPTH_LOG2 = 7,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory plus boot loader for the single-cycle MIPS core.
// After reset (or load_req in RUN) the memory is zeroed, then filled from a
// byte stream: 16-bit big-endian word count, then big-endian 32-bit words.
// The core is held in reset until the last word lands.
//   clk, rst_n      : clock, async active-low reset
//   in_data/in_valid/in_ready : boot byte stream handshake
//   load_req        : reload pulse, honoured only in RUN
//   IR_addr/IR      : combinational instruction fetch
//   core_rst_n      : registered active-low core reset
//   words_loaded    : words actually written this load
//   overflow        : sticky, header count exceeded memory depth
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             load_req,
  input  logic [31:0]      IR_addr,
  output logic [31:0]      IR,
  output logic             core_rst_n,
  output logic [CNT_W-1:0] words_loaded,
  output logic             overflow
);
  localparam int               DEPTH   = 2**DEPTH_LOG2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic [7:0]            cnt_hi;
  logic [CNT_W-1:0]      count, word_cnt, word_cnt_inc, hdr_count;
  logic [1:0]            byte_cnt;
  logic [23:0]           asm_q;     // first three bytes of the word in flight
  logic                  xfer, word_done;

  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [31:0]           wdata, rd;
  logic                  addr_ok;

  assign xfer         = in_valid && in_ready;
  assign hdr_count    = CNT_W'({cnt_hi, in_data});
  assign word_done    = (state == DATA) && xfer && (byte_cnt == 2'd3);
  assign word_cnt_inc = word_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:  if (&clr_idx) state_nxt = HDR_HI;
      HDR_HI: if (xfer) state_nxt = HDR_LO;
      HDR_LO: if (xfer) state_nxt = (hdr_count == '0) ? RUN : DATA;
      DATA:   if (word_done && word_cnt_inc == count) state_nxt = RUN;
      RUN:    if (load_req) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Outputs: stream handshake and the single memory write port
  always_comb begin
    in_ready = 1'b0;
    we       = 1'b0;
    waddr    = clr_idx;
    wdata    = NOP_WORD;
    case (state)
      CLEAR:  we = 1'b1;
      HDR_HI, HDR_LO: in_ready = 1'b1;
      DATA: begin
        in_ready = 1'b1;
        // Words beyond the memory are consumed but dropped.
        if (word_done && word_cnt < DEPTH_C) begin
          we    = 1'b1;
          waddr = word_cnt[DEPTH_LOG2-1:0];
          wdata = {asm_q, in_data};
        end
      end
      default: ;
    endcase
  end

  // Datapath: counters, header, byte assembler, status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx      <= '0;
      cnt_hi       <= '0;
      count        <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      core_rst_n   <= 1'b0;
      overflow     <= 1'b0;
      words_loaded <= '0;
    end else begin
      core_rst_n <= (state_nxt == RUN);
      case (state)
        CLEAR:  clr_idx <= clr_idx + 1'b1;   // wraps back to 0 on exit
        HDR_HI: if (xfer) cnt_hi <= in_data;
        HDR_LO: if (xfer) begin
          count    <= hdr_count;
          overflow <= (hdr_count > DEPTH_C);
          word_cnt <= '0;
          byte_cnt <= '0;
        end
        DATA: if (xfer) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_q    <= {asm_q[15:0], in_data};
          if (word_done) begin
            word_cnt <= word_cnt_inc;
            if (word_cnt < DEPTH_C) words_loaded <= words_loaded + CNT_W'(1);
          end
        end
        RUN: if (load_req) begin
          overflow     <= 1'b0;
          words_loaded <= '0;
          clr_idx      <= '0;
        end
        default: ;
      endcase
    end
  end

  imem_ram #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (IR_addr[DEPTH_LOG2+1:2]),
    .rdata (rd)
  );

  // Only word-aligned addresses inside the array fetch real data. During
  // CLEAR the array may still hold power-up garbage, so the output is forced
  // to NOP there to keep IR defined in every state.
  assign addr_ok = (IR_addr[31:DEPTH_LOG2+2] == '0) && (IR_addr[1:0] == 2'b00);
  assign IR      = (addr_ok && state != CLEAR) ? rd : NOP_WORD;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench: stimulus loads programs and pushes expected IR values for
// chosen fetch addresses; a monitor drives IR_addr and compares while the core
// is out of reset.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        load_req;
  logic [31:0] IR_addr;
  logic [31:0] IR;
  logic        core_rst_n;
  logic [15:0] words_loaded;
  logic        overflow;

  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .load_req(load_req), .IR_addr(IR_addr), .IR(IR),
    .core_rst_n(core_rst_n), .words_loaded(words_loaded), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [31:0] exp;} sb_t;
  sb_t         sb_q[$];
  logic [31:0] wq[$];          // words of the program being streamed
  logic [31:0] exp_mem[128];   // reference image
  int n_chk = 0, n_fail = 0;
  int cyc = 0, c0 = 0, done_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: fetch and compare whenever the core would be running
  initial begin
    sb_t e;
    IR_addr = '0;
    forever begin
      @(negedge clk);
      if (core_rst_n === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        IR_addr = e.addr;
        #1;
        chk($sformatf("IR@%h", e.addr), IR, e.exp);
      end
    end
  end

  task automatic wait_sb();
    int g = 0;
    while (sb_q.size() > 0 && g < 5000) begin @(negedge clk); g++; end
    if (sb_q.size() > 0) begin
      chk("sb_drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // mode 0: continuous, 1: idle cycle before every byte, 2: random idles
  task automatic send_byte(input logic [7:0] b, input int mode);
    int g = 0;
    int idle;
    idle = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (idle) begin in_valid = 1'b0; in_data = 8'($urandom); @(negedge clk); end
    in_data = b; in_valid = 1'b1;
    while (in_ready !== 1'b1 && g < 1000) begin @(negedge clk); g++; end
    if (in_ready !== 1'b1) begin chk("send_timeout", {31'd0, in_ready}, 32'd1); return; end
    @(negedge clk);
  endtask

  task automatic push_image();
    logic [31:0] a;
    for (int i = 0; i < 128; i++) sb_q.push_back(sb_t'{32'(i * 4), exp_mem[i]});
    sb_q.push_back(sb_t'{32'h0000_0202, 32'h0});
    sb_q.push_back(sb_t'{32'h0000_0400, 32'h0});
    repeat (4) begin
      a = ($urandom_range(1, 4095) << 9) | ($urandom & 32'h1FC);
      sb_q.push_back(sb_t'{a, 32'h0});
      a = ($urandom & 32'h1FC) | 32'($urandom_range(1, 3));
      sb_q.push_back(sb_t'{a, 32'h0});
    end
  endtask

  task automatic do_load(input int cnt, input int mode);
    logic [15:0] c16;
    logic [31:0] w;
    int          nl;
    c16 = 16'(cnt);
    send_byte(c16[15:8], mode);
    send_byte(c16[7:0], mode);
    chk("overflow_hdr", {31'd0, overflow}, {31'd0, cnt > 128});
    if (cnt == 0) chk("run_after_hdr", {31'd0, core_rst_n}, 32'd1);
    for (int i = 0; i < cnt; i++) begin
      w = wq[i];
      for (int b = 0; b < 4; b++) send_byte(w[31 - 8*b -: 8], mode);
    end
    in_valid = 1'b0;
    done_cyc = cyc;
    nl = (cnt > 128) ? 128 : cnt;
    chk("core_rst_n_run", {31'd0, core_rst_n}, 32'd1);
    chk("in_ready_run", {31'd0, in_ready}, 32'd0);
    chk("words_loaded", {16'd0, words_loaded}, 32'(nl));
    chk("overflow_run", {31'd0, overflow}, {31'd0, cnt > 128});
    for (int i = 0; i < 128; i++) exp_mem[i] = (i < cnt) ? wq[i] : 32'h0;
    push_image();
    wait_sb();
  endtask

  task automatic reload();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("reload_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("reload_overflow", {31'd0, overflow}, 32'd0);
    chk("reload_words", {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic rand_prog(input int cnt);
    wq.delete();
    for (int i = 0; i < cnt; i++) wq.push_back($urandom);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; load_req = 1'b0;
    #12;
    chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    // Basic two-word program with boot latency
    @(negedge clk); rst_n = 1'b1; c0 = cyc;
    wq = '{32'h2008_0005, 32'h0000_0000};
    do_load(2, 0);
    chk("boot_latency", 32'(done_cyc - c0), 32'd138);

    // Empty program
    reload();
    do_load(0, 0);

    // Oversized program: 130 words, only 128 stored
    reload();
    wq.delete();
    for (int i = 0; i < 130; i++) wq.push_back(32'hA000_0000 + 32'(i));
    do_load(130, 0);

    // Reload clears old image and overflow
    reload();
    wq = '{32'hFFFF_FFFF};
    do_load(1, 0);

    // Valid toggling every other cycle
    reload();
    n = $urandom_range(1, 40);
    rand_prog(n);
    do_load(n, 1);

    // Random idles, random length
    repeat (2) begin
      reload();
      n = $urandom_range(1, 60);
      rand_prog(n);
      do_load(n, 2);
    end

    // Asynchronous reset in the middle of DATA
    reload();
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
    chk("in_ready_data", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("async_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; c0 = cyc;
    rand_prog(2);
    do_load(2, 0);
    chk("reboot_latency", 32'(done_cyc - c0), 32'd138);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
